ahb_slave_if: RTL

AHB-Lite responder front-end of the AHB-to-APB bridge. It accepts transfers from an AHB master (hclk/haddr/hwdata/hwrite/htrans/hreadyin) and decodes the address into one of three peripheral regions. It forwards each transfer to the bridge back-end (APB FSM) as a single request and stretches the data phase with hreadyout until the back-end completes. Unmapped addresses and back-end timeouts return the AHB two-cycle ERROR response.

---
 rtl/ahb_pkg.sv | 28 ++
 rtl/ahb_addr_decode.sv | 27 ++
 rtl/ahb_slave_if.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite codes, FSM state encoding and the address map
// used by the AHB-to-APB bridge front-end and its select logic.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Each region spans 2**REGION_LSB bytes (64 MB).
  localparam int REGION_LSB = 26;

  localparam logic [31:0] DEF_BASE0 = 32'h8000_0000;
  localparam logic [31:0] DEF_BASE1 = 32'h8400_0000;
  localparam logic [31:0] DEF_BASE2 = 32'h8800_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_addr_decode.sv
// Region decoder: compares the upper address bits against each base and
// returns a one-hot select plus an unmapped flag. Purely combinational.
module ahb_addr_decode
  import ahb_pkg::*;
#(
  parameter int              ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE0 = DEF_BASE0,
  parameter logic [ADDR_W-1:0] BASE1 = DEF_BASE1,
  parameter logic [ADDR_W-1:0] BASE2 = DEF_BASE2
) (
  input  logic [ADDR_W-1:0] i_haddr,
  output logic [2:0]        o_sel,
  output logic              o_unmapped
);

  logic [ADDR_W-REGION_LSB-1:0] w_tag;
  logic                         w_unused_low;

  assign w_tag        = i_haddr[ADDR_W-1:REGION_LSB];
  assign w_unused_low = ^i_haddr[REGION_LSB-1:0];

  assign o_sel[0]   = (w_tag == BASE0[ADDR_W-1:REGION_LSB]);
  assign o_sel[1]   = (w_tag == BASE1[ADDR_W-1:REGION_LSB]);
  assign o_sel[2]   = (w_tag == BASE2[ADDR_W-1:REGION_LSB]);
  assign o_unmapped = ~|o_sel;

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite responder front-end of the AHB-to-APB bridge: decodes, forwards one
// request per transfer to the APB back-end and stretches the data phase.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int              ADDR_W  = 32,
  parameter int              DATA_W  = 32,
  parameter int              TIMEOUT = 16,
  parameter logic [ADDR_W-1:0] BASE0 = DEF_BASE0,
  parameter logic [ADDR_W-1:0] BASE1 = DEF_BASE1,
  parameter logic [ADDR_W-1:0] BASE2 = DEF_BASE2
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hwrite,
  input  logic [1:0]        htrans,
  input  logic              hreadyin,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic              bk_req,
  output logic [ADDR_W-1:0] bk_addr,
  output logic              bk_write,
  output logic [2:0]        bk_sel,
  output logic [DATA_W-1:0] bk_wdata,
  output logic              bk_abort,
  input  logic              bk_done,
  input  logic [DATA_W-1:0] bk_rdata
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            r_state;
  logic              r_hreadyout;
  logic              r_hresp;
  logic [DATA_W-1:0] r_hrdata;
  logic              r_bk_req;
  logic              r_bk_abort;
  logic              r_bk_write;
  logic [2:0]        r_bk_sel;
  logic [ADDR_W-1:0] r_bk_addr;
  logic [DATA_W-1:0] r_bk_wdata;
  logic [CNT_W-1:0]  r_cnt;

  logic [2:0] w_sel;
  logic       w_unmapped;
  logic       w_accept;
  logic       w_unused_htrans0;

  ahb_addr_decode #(
    .ADDR_W (ADDR_W),
    .BASE0  (BASE0),
    .BASE1  (BASE1),
    .BASE2  (BASE2)
  ) u_decode (
    .i_haddr    (haddr),
    .o_sel      (w_sel),
    .o_unmapped (w_unmapped)
  );

  // BUSY and IDLE differ only in htrans[0]; neither starts a transfer.
  assign w_accept         = r_hreadyout & hreadyin & htrans[1];
  assign w_unused_htrans0 = htrans[0];

  always_ff @(posedge hclk) begin
    // NOTE: reset is synchronous, so it is tested first inside the clocked block.
    if (hreset) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_hrdata    <= '0;
      r_bk_req    <= 1'b0;
      r_bk_abort  <= 1'b0;
      r_bk_write  <= 1'b0;
      r_bk_sel    <= '0;
      r_bk_addr   <= '0;
      r_bk_wdata  <= '0;
      r_cnt       <= '0;
    end else begin
      // NOTE: non-blocking defaults make the pulses one cycle wide; a later
      // assignment in the case below overrides them for this edge only.
      r_bk_req   <= 1'b0;
      r_bk_abort <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
          if (w_accept) begin
            r_hreadyout <= 1'b0;
            if (w_unmapped) begin
              r_state <= ST_ERR1;
              r_hresp <= HRESP_ERROR;
            end else begin
              r_state    <= ST_WDATA;
              r_bk_addr  <= haddr;
              r_bk_write <= hwrite;
              r_bk_sel   <= w_sel;
            end
          end
        end
        ST_WDATA: begin
          if (r_bk_write) r_bk_wdata <= hwdata;
          r_bk_req <= 1'b1;
          r_cnt    <= '0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes priority over a timeout on the same edge.
          if (bk_done) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            if (!r_bk_write) r_hrdata <= bk_rdata;
          end else if (r_cnt == CNT_LAST) begin
            r_state    <= ST_ERR1;
            r_hresp    <= HRESP_ERROR;
            r_bk_abort <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = r_hrdata;
  assign bk_req    = r_bk_req;
  assign bk_abort  = r_bk_abort;
  assign bk_write  = r_bk_write;
  assign bk_sel    = r_bk_sel;
  assign bk_addr   = r_bk_addr;
  assign bk_wdata  = r_bk_wdata;

endmodule
